sap1_sequencer: RTL and testbench

- Controller-sequencer for the SAP-1 datapath.
- Steps a T-state ring and decodes the instruction-register opcode into the 12-bit control word.
- The control word drives PC, MAR, RAM, IR, A, B, output register and the add/subtract unit (alu_sub/alu_en).
- Sits directly upstream of the add/subtract unit. It supplies that unit's subtract select and bus enable, and inserts wait states for the unit's registered result.

---
 rtl/sap1_pkg.sv | 85 ++++++++
 rtl/sap1_ctrl_decode.sv | 55 +++++
 rtl/sap1_sequencer.sv | 124 ++++++++++++
 tb/tb_sap1_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// -----------------------------------------------------------------------------
// sap1_pkg
// Shared definitions for the SAP-1 controller-sequencer:
//   - opcode encodings (LDA, ADD, SUB, OUT, HLT; everything else is a NOP)
//   - control-word width and bit indices, plus single-bit masks
//   - sequencer state encoding and the state enum built on it
//   - fixed fetch-phase control words (T1, T2, T3)
//   - small opcode classification helpers
// -----------------------------------------------------------------------------
package sap1_pkg;

    // Opcodes (IR upper nibble)
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Control word layout, MSB to LSB
    localparam int CTRL_W     = 12;
    localparam int CB_PC_INC  = 11;
    localparam int CB_PC_EN   = 10;
    localparam int CB_MAR_LD  = 9;
    localparam int CB_RAM_EN  = 8;
    localparam int CB_IR_LD   = 7;
    localparam int CB_IR_EN   = 6;
    localparam int CB_A_LD    = 5;
    localparam int CB_A_EN    = 4;
    localparam int CB_ALU_SUB = 3;
    localparam int CB_ALU_EN  = 2;
    localparam int CB_B_LD    = 1;
    localparam int CB_OUT_LD  = 0;

    localparam logic [CTRL_W-1:0] M_PC_INC  = CTRL_W'(1) << CB_PC_INC;
    localparam logic [CTRL_W-1:0] M_PC_EN   = CTRL_W'(1) << CB_PC_EN;
    localparam logic [CTRL_W-1:0] M_MAR_LD  = CTRL_W'(1) << CB_MAR_LD;
    localparam logic [CTRL_W-1:0] M_RAM_EN  = CTRL_W'(1) << CB_RAM_EN;
    localparam logic [CTRL_W-1:0] M_IR_LD   = CTRL_W'(1) << CB_IR_LD;
    localparam logic [CTRL_W-1:0] M_IR_EN   = CTRL_W'(1) << CB_IR_EN;
    localparam logic [CTRL_W-1:0] M_A_LD    = CTRL_W'(1) << CB_A_LD;
    localparam logic [CTRL_W-1:0] M_A_EN    = CTRL_W'(1) << CB_A_EN;
    localparam logic [CTRL_W-1:0] M_ALU_SUB = CTRL_W'(1) << CB_ALU_SUB;
    localparam logic [CTRL_W-1:0] M_ALU_EN  = CTRL_W'(1) << CB_ALU_EN;
    localparam logic [CTRL_W-1:0] M_B_LD    = CTRL_W'(1) << CB_B_LD;
    localparam logic [CTRL_W-1:0] M_OUT_LD  = CTRL_W'(1) << CB_OUT_LD;

    // Fetch phase is opcode-independent
    localparam logic [CTRL_W-1:0] CW_T1 = M_PC_EN  | M_MAR_LD;
    localparam logic [CTRL_W-1:0] CW_T2 = M_PC_INC;
    localparam logic [CTRL_W-1:0] CW_T3 = M_RAM_EN | M_IR_LD;

    // State encoding
    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_T1   = 4'd1;
    localparam logic [3:0] ST_T2   = 4'd2;
    localparam logic [3:0] ST_T3   = 4'd3;
    localparam logic [3:0] ST_T4   = 4'd4;
    localparam logic [3:0] ST_T5   = 4'd5;
    localparam logic [3:0] ST_W    = 4'd6;
    localparam logic [3:0] ST_T6   = 4'd7;
    localparam logic [3:0] ST_HALT = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE = ST_IDLE,
        S_T1   = ST_T1,
        S_T2   = ST_T2,
        S_T3   = ST_T3,
        S_T4   = ST_T4,
        S_T5   = ST_T5,
        S_W    = ST_W,
        S_T6   = ST_T6,
        S_HALT = ST_HALT
    } state_t;

    // ADD/SUB use the add/subtract unit and its wait states
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Instructions that fetch a memory operand in T4/T5
    function automatic logic has_operand(input logic [3:0] op);
        return (op == OP_LDA) || is_alu_op(op);
    endfunction

endpackage

// File: rtl/sap1_ctrl_decode.sv
// -----------------------------------------------------------------------------
// sap1_ctrl_decode
// Purely combinational mapping (state, opcode) -> control word.
// Ports:
//   state   in  state_t        current sequencer state
//   opcode  in  [3:0]          IR upper nibble (only looked at from T4 on)
//   ctrl    out [CTRL_W-1:0]   control word, bit layout from sap1_pkg
// -----------------------------------------------------------------------------
import sap1_pkg::*;

module sap1_ctrl_decode (
    input  state_t            state,
    input  logic [3:0]        opcode,
    output logic [CTRL_W-1:0] ctrl
);

    always_comb begin
        // NOTE: default assigned first so every path drives ctrl and no latch is inferred.
        ctrl = '0;
        case (state)
            S_T1: ctrl = CW_T1;
            S_T2: ctrl = CW_T2;
            S_T3: ctrl = CW_T3;
            S_T4: begin
                if (has_operand(opcode)) begin
                    ctrl = M_IR_EN | M_MAR_LD;
                end else if (opcode == OP_OUT) begin
                    ctrl = M_A_EN | M_OUT_LD;
                end
            end
            S_T5: begin
                if (opcode == OP_LDA) begin
                    ctrl = M_RAM_EN | M_A_LD;
                end else if (is_alu_op(opcode)) begin
                    ctrl = M_RAM_EN | M_B_LD;
                end
            end
            // Hold the subtract select steady while the unit's result settles
            S_W: begin
                if (opcode == OP_SUB) begin
                    ctrl = M_ALU_SUB;
                end
            end
            S_T6: begin
                if (opcode == OP_ADD) begin
                    ctrl = M_ALU_EN | M_A_LD;
                end else if (opcode == OP_SUB) begin
                    ctrl = M_ALU_EN | M_A_LD | M_ALU_SUB;
                end
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/sap1_sequencer.sv
// -----------------------------------------------------------------------------
// sap1_sequencer
// SAP-1 controller-sequencer: steps the T-state ring, inserts ALU_LAT wait
// states for ADD/SUB, and decodes the control word.
// Parameter:
//   ALU_LAT  wait states between B load and A load for ADD/SUB (0..3)
// Ports:
//   clk_i     in  1   system clock
//   rstn_i    in  1   asynchronous active-low reset
//   opcode_i  in  4   IR upper nibble, valid from T4 onward
//   ctrl_o    out 12  control word (combinational from state and opcode_i)
//   tstate_o  out 6   one-hot T1..T6, zero in IDLE, W and HALT
//   halt_o    out 1   sticky halt flag, cleared only by reset
// Build option:
//   SAP1_SEQ_EARLY_RET_EN  when defined, LDA returns to T1 after T5 and
//                          OUT/NOP after T4; ADD/SUB are unchanged.
// -----------------------------------------------------------------------------
import sap1_pkg::*;

module sap1_sequencer #(
    parameter int ALU_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [3:0]        opcode_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [5:0]        tstate_o,
    output logic              halt_o
);

    if (ALU_LAT < 0 || ALU_LAT > 3) begin : g_bad_alu_lat
        $error("sap1_sequencer: ALU_LAT must be in 0..3");
    end

`ifdef SAP1_SEQ_EARLY_RET_EN
    localparam bit EARLY_RET = 1'b1;
`else
    localparam bit EARLY_RET = 1'b0;
`endif

    // Counter holds remaining W cycles minus one; W exits when it reads zero
    localparam logic [1:0] WAIT_INIT = (ALU_LAT > 0) ? 2'(ALU_LAT - 1) : 2'd0;

    state_t     state_q, state_d;
    logic [1:0] wait_q, wait_d;
    logic       halt_q, halt_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            halt_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q <= state_d;
            wait_q  <= wait_d;
            halt_q  <= halt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        halt_d  = halt_q;
        case (state_q)
            S_IDLE: state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3:   state_d = S_T4;
            S_T4: begin
                if (opcode_i == OP_HLT) begin
                    state_d = S_HALT;
                    halt_d  = 1'b1;
                end else if (EARLY_RET && !has_operand(opcode_i)) begin
                    state_d = S_T1;
                end else begin
                    state_d = S_T5;
                end
            end
            S_T5: begin
                wait_d = WAIT_INIT;
                if (is_alu_op(opcode_i)) begin
                    state_d = (ALU_LAT == 0) ? S_T6 : S_W;
                end else if (EARLY_RET && opcode_i == OP_LDA) begin
                    state_d = S_T1;
                end else begin
                    state_d = S_T6;
                end
            end
            S_W: begin
                if (wait_q == 2'd0) begin
                    state_d = S_T6;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            S_T6:   state_d = S_T1;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tstate_o = '0;
        case (state_q)
            S_T1: tstate_o = 6'b000001;
            S_T2: tstate_o = 6'b000010;
            S_T3: tstate_o = 6'b000100;
            S_T4: tstate_o = 6'b001000;
            S_T5: tstate_o = 6'b010000;
            S_T6: tstate_o = 6'b100000;
            default: tstate_o = '0;
        endcase
    end

    sap1_ctrl_decode u_decode (
        .state  (state_q),
        .opcode (opcode_i),
        .ctrl   (ctrl_o)
    );

    assign halt_o = halt_q;

endmodule

// File: tb/tb_sap1_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sap1_sequencer
// Two sequencer instances (ALU_LAT=1 and ALU_LAT=2). A behavioural model
// lists, per instruction, the {ctrl, tstate, halt} value of every cycle;
// the bench drives random opcodes during fetch and compares each cycle.
// -----------------------------------------------------------------------------
module tb_sap1_sequencer;

`ifdef SAP1_SEQ_EARLY_RET_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    // Control bits by position, MSB to LSB
    localparam logic [11:0] PC_INC  = 12'h800;
    localparam logic [11:0] PC_EN   = 12'h400;
    localparam logic [11:0] MAR_LD  = 12'h200;
    localparam logic [11:0] RAM_EN  = 12'h100;
    localparam logic [11:0] IR_LD   = 12'h080;
    localparam logic [11:0] IR_EN   = 12'h040;
    localparam logic [11:0] A_LD    = 12'h020;
    localparam logic [11:0] A_EN    = 12'h010;
    localparam logic [11:0] ALU_SUB = 12'h008;
    localparam logic [11:0] ALU_EN  = 12'h004;
    localparam logic [11:0] B_LD    = 12'h002;
    localparam logic [11:0] OUT_LD  = 12'h001;

    localparam logic [3:0] LDA = 4'h0, ADD = 4'h1, SUB = 4'h2, OUT = 4'hE, HLT = 4'hF;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [3:0]  op1, op2;
    logic [11:0] ctrl1, ctrl2;
    logic [5:0]  ts1, ts2;
    logic        h1, h2;

    int checks = 0;
    int errors = 0;

    // One entry per cycle: {ctrl[11:0], tstate[5:0], halt}
    logic [18:0] exp_q[$];
    logic [18:0] obs_q[$];

    always #5 clk_i = ~clk_i;

    sap1_sequencer #(.ALU_LAT(1)) dut1 (
        .clk_i(clk_i), .rstn_i(rstn_i), .opcode_i(op1),
        .ctrl_o(ctrl1), .tstate_o(ts1), .halt_o(h1)
    );

    sap1_sequencer #(.ALU_LAT(2)) dut2 (
        .clk_i(clk_i), .rstn_i(rstn_i), .opcode_i(op2),
        .ctrl_o(ctrl2), .tstate_o(ts2), .halt_o(h2)
    );

    function automatic logic [18:0] observe(input int which);
        return (which == 1) ? {ctrl1, ts1, h1} : {ctrl2, ts2, h2};
    endfunction

    task automatic set_op(input int which, input logic [3:0] v);
        if (which == 1) op1 = v;
        else            op2 = v;
    endtask

    function automatic void push(input logic [11:0] c, input logic [5:0] t, input logic h);
        exp_q.push_back({c, t, h});
    endfunction

    // Instruction-level model: every cycle the instruction occupies
    function automatic void model(input logic [3:0] op, input int lat);
        logic [11:0] sub_bit;
        sub_bit = (op == SUB) ? ALU_SUB : 12'h000;
        push(PC_EN | MAR_LD, 6'd1, 1'b0);
        push(PC_INC,         6'd2, 1'b0);
        push(RAM_EN | IR_LD, 6'd4, 1'b0);
        case (op)
            LDA: begin
                push(IR_EN | MAR_LD, 6'd8, 1'b0);
                push(RAM_EN | A_LD, 6'd16, 1'b0);
                if (!EARLY) push(12'h000, 6'd32, 1'b0);
            end
            ADD, SUB: begin
                push(IR_EN | MAR_LD, 6'd8, 1'b0);
                push(RAM_EN | B_LD, 6'd16, 1'b0);
                for (int k = 0; k < lat; k++) push(sub_bit, 6'd0, 1'b0);
                push(ALU_EN | A_LD | sub_bit, 6'd32, 1'b0);
            end
            OUT: begin
                push(A_EN | OUT_LD, 6'd8, 1'b0);
                if (!EARLY) begin
                    push(12'h000, 6'd16, 1'b0);
                    push(12'h000, 6'd32, 1'b0);
                end
            end
            HLT: begin
                push(12'h000, 6'd8, 1'b0);
                for (int k = 0; k < 20; k++) push(12'h000, 6'd0, 1'b1);
            end
            default: begin
                push(12'h000, 6'd8, 1'b0);
                if (!EARLY) begin
                    push(12'h000, 6'd16, 1'b0);
                    push(12'h000, 6'd32, 1'b0);
                end
            end
        endcase
    endfunction

    // Runs one instruction on one instance; random opcode during fetch and HALT
    task automatic exec_instr(input int which, input logic [3:0] op);
        int n0;
        n0 = exp_q.size();
        model(op, (which == 1) ? 1 : 2);
        for (int i = n0; i < exp_q.size(); i++) begin
            @(posedge clk_i);
            #1;
            if ((i - n0) < 3 || (op == HLT && (i - n0) >= 4)) set_op(which, 4'($urandom));
            else                                               set_op(which, op);
            #1;
            obs_q.push_back(observe(which));
        end
    endtask

    // Leaves both instances in IDLE; the next clock edge enters T1
    task automatic apply_reset();
        rstn_i = 1'b0;
        op1 = 4'h0;
        op2 = 4'h0;
        exp_q.delete();
        obs_q.delete();
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        logic [18:0] o;
        rstn_i = 1'b0;
        op1 = 4'h0;
        op2 = 4'h0;
        repeat (3) @(posedge clk_i);
        #2;
        for (int d = 1; d <= 2; d++) begin
            o = observe(d);
            checks++;
            if (o !== 19'h0) begin
                errors++;
                $display("FAIL reset_hold dut%0d got ctrl=%h t=%b h=%b want 0", d, o[18:7], o[6:1], o[0]);
            end
        end
        #1 rstn_i = 1'b1;
        #1;
        for (int d = 1; d <= 2; d++) begin
            o = observe(d);
            checks++;
            if (o !== 19'h0) begin
                errors++;
                $display("FAIL idle dut%0d got ctrl=%h t=%b h=%b want 0", d, o[18:7], o[6:1], o[0]);
            end
        end
        exp_q.delete();
        obs_q.delete();
        exec_instr(1, LDA);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL fetch_lda cyc %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_add();
        apply_reset();
        exec_instr(1, ADD);
        exec_instr(1, LDA);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL add_lat1 cyc %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_sub();
        apply_reset();
        exec_instr(2, SUB);
        exec_instr(2, OUT);
        exec_instr(2, SUB);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL sub_lat2 cyc %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_out_nop();
        apply_reset();
        exec_instr(1, OUT);
        exec_instr(1, 4'h5);
        exec_instr(1, OUT);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL out_nop cyc %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] op;
        for (int d = 1; d <= 2; d++) begin
            apply_reset();
            for (int n = 0; n < 25; n++) begin
                op = 4'($urandom);
                if (op == HLT) op = ($urandom_range(0, 1) == 0) ? ADD : SUB;
                exec_instr(d, op);
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random dut%0d cyc %0d got %h want %h", d, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_halt();
        logic [18:0] o;
        apply_reset();
        exec_instr(2, ADD);
        exec_instr(2, HLT);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL halt cyc %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        rstn_i = 1'b0;
        #1;
        o = observe(2);
        checks++;
        if (o !== 19'h0) begin
            errors++;
            $display("FAIL halt_clear got ctrl=%h t=%b h=%b want 0", o[18:7], o[6:1], o[0]);
        end
        @(posedge clk_i);
        #1 rstn_i = 1'b1;
        #1;
        exp_q.delete();
        obs_q.delete();
        exec_instr(2, LDA);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL halt_restart cyc %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_add();
        logic [18:0] o;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_i);
            #1 op1 = (k < 3) ? 4'($urandom) : ADD;
        end
        #1;
        checks++;
        if (ctrl1 !== (RAM_EN | B_LD)) begin
            errors++;
            $display("FAIL mid_add_t5 got ctrl=%h want %h", ctrl1, RAM_EN | B_LD);
        end
        rstn_i = 1'b0;
        #1;
        o = observe(1);
        checks++;
        if (o !== 19'h0) begin
            errors++;
            $display("FAIL mid_add_reset got ctrl=%h t=%b h=%b want 0", o[18:7], o[6:1], o[0]);
        end
        @(posedge clk_i);
        #1 rstn_i = 1'b1;
        #1;
        exp_q.delete();
        obs_q.delete();
        exec_instr(1, ADD);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL mid_add_restart cyc %0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i = 1'b0;
        op1 = 4'h0;
        op2 = 4'h0;
        test_reset();
        test_add();
        test_sub();
        test_out_nop();
        test_back_to_back();
        test_halt();
        test_reset_mid_add();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
